// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback/commit stage: execute-stage result bundle,
// commit-trace entry, and the x0 register constant.
package wb_commit_pkg;

  localparam int WB_XLEN = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  // Registered output of an execute datapath
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] result;
    logic [WB_XLEN-1:0] pc;
    logic [31:0]        inst;
  } execute_signals_t;

  // One committed instruction as recorded in the trace FIFO
  typedef struct packed {
    logic [WB_XLEN-1:0] pc;
    logic [31:0]        inst;
  } commit_trace_t;

  // Number of instructions retiring this cycle (0..2)
  function automatic logic [1:0] retire_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Commit-trace FIFO: up to two pushes (older entry first) and one pop per
// cycle. Pushes beyond the free space drop the younger entries and set a
// sticky overflow flag. DEPTH must be a power of two, at least 2.
module commit_trace_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_a_i,
  input  commit_trace_t ent_a_i,
  input  logic          push_b_i,
  input  commit_trace_t ent_b_i,
  input  logic          pop_i,
  output logic          valid_o,
  output commit_trace_t head_o,
  output logic          overflow_o
);

  localparam int AW = $clog2(DEPTH);

  commit_trace_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          pop, req0, req1, acc0, acc1;
  logic [AW:0]   free;
  commit_trace_t ent0;

  // Push/pop arbitration: the slot freed by a same-cycle pop is usable
  always_comb begin
    pop   = pop_i & (cnt_q != '0);
    free  = (AW+1)'(DEPTH) - cnt_q + {{AW{1'b0}}, pop};
    req0  = push_a_i | push_b_i;
    req1  = push_a_i & push_b_i;
    ent0  = push_a_i ? ent_a_i : ent_b_i;
    acc0  = req0 & (free >= (AW+1)'(1));
    acc1  = req1 & (free >= (AW+1)'(2));
    wr_d  = wr_q + AW'(acc0) + AW'(acc1);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(pop);
    ovf_d = ovf_q | (req0 & ~acc0) | (req1 & ~acc1);
  end

  // Pointer, occupancy and overflow state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage; contents are only observable through a valid head
  always_ff @(posedge clk) begin
    if (acc0) mem_q[wr_q] <= ent0;
    if (acc1) mem_q[wr_q + AW'(1)] <= ent_b_i;
  end

  assign valid_o    = (cnt_q != '0);
  assign head_o     = valid_o ? mem_q[rd_q] : '0;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage of the dual-issue pipeline. Lane A is the older
// instruction, lane B the younger. Optional commit trace FIFO is enabled by
// defining WB_COMMIT_TRACE_EN.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int XLEN        = WB_XLEN,
  parameter int CNT_W       = 64,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  execute_signals_t ex_a_in,
  input  execute_signals_t ex_b_in,
  input  logic             stall_in,
  output logic             rf_we_a,
  output logic [4:0]       rf_waddr_a,
  output logic [XLEN-1:0]  rf_wdata_a,
  output logic             rf_we_b,
  output logic [4:0]       rf_waddr_b,
  output logic [XLEN-1:0]  rf_wdata_b,
  output logic             fwd_a_valid,
  output logic [4:0]       fwd_a_rd,
  output logic [XLEN-1:0]  fwd_a_data,
  output logic             fwd_b_valid,
  output logic [4:0]       fwd_b_rd,
  output logic [XLEN-1:0]  fwd_b_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             trace_valid,
  output logic [XLEN-1:0]  trace_pc,
  output logic [31:0]      trace_inst,
  input  logic             trace_ready,
  output logic             trace_overflow
);

  execute_signals_t wb_a_q, wb_b_q;
  logic [CNT_W-1:0] cycle_q, instret_q;

  logic wr_a, wr_b, waw, commit_a, commit_b;
  logic [1:0] n_ret;

  // WB pipeline registers: capture when not stalled, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_a_q <= '0;
      wb_b_q <= '0;
    end else if (!stall_in) begin
      wb_a_q <= ex_a_in;
      wb_b_q <= ex_b_in;
    end
  end

  // Commit decode; lane B is younger so it wins a same-rd conflict
  always_comb begin
    wr_a     = wb_a_q.valid & wb_a_q.reg_write & (wb_a_q.rd != REG_X0);
    wr_b     = wb_b_q.valid & wb_b_q.reg_write & (wb_b_q.rd != REG_X0);
    waw      = wr_a & wr_b & (wb_a_q.rd == wb_b_q.rd);
    commit_a = wb_a_q.valid & ~stall_in;
    commit_b = wb_b_q.valid & ~stall_in;
    n_ret    = retire_count(commit_a, commit_b);
  end

  assign rf_we_a     = wr_a & ~waw & ~stall_in;
  assign rf_waddr_a  = wb_a_q.rd;
  assign rf_wdata_a  = wb_a_q.result;
  assign rf_we_b     = wr_b & ~stall_in;
  assign rf_waddr_b  = wb_b_q.rd;
  assign rf_wdata_b  = wb_b_q.result;

  // Forwarding ignores stall: the WB value is valid while it is held
  assign fwd_a_valid = wr_a & ~waw;
  assign fwd_a_rd    = wb_a_q.rd;
  assign fwd_a_data  = wb_a_q.result;
  assign fwd_b_valid = wr_b;
  assign fwd_b_rd    = wb_b_q.rd;
  assign fwd_b_data  = wb_b_q.result;

  // Free-running cycle and retired-instruction counters (wrap naturally)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_q + CNT_W'(1);
      instret_q <= instret_q + CNT_W'(n_ret);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

`ifdef WB_COMMIT_TRACE_EN
  commit_trace_t trc_head;

  commit_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace (
    .clk       (clk),
    .reset     (reset),
    .push_a_i  (commit_a),
    .ent_a_i   ('{pc: wb_a_q.pc, inst: wb_a_q.inst}),
    .push_b_i  (commit_b),
    .ent_b_i   ('{pc: wb_b_q.pc, inst: wb_b_q.inst}),
    .pop_i     (trace_ready),
    .valid_o   (trace_valid),
    .head_o    (trc_head),
    .overflow_o(trace_overflow)
  );

  assign trace_pc   = trc_head.pc;
  assign trace_inst = trc_head.inst;
`else
  logic unused_trace;
  assign unused_trace   = ^{trace_ready, wb_a_q.pc, wb_a_q.inst, wb_b_q.pc, wb_b_q.inst};
  assign trace_valid    = 1'b0;
  assign trace_pc       = '0;
  assign trace_inst     = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit. Define WB_COMMIT_TRACE_EN for both bench and
// RTL to exercise the trace FIFO; otherwise its outputs are checked tied off.
module tb_wb_commit;
  import wb_commit_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  execute_signals_t ex_a, ex_b;
  logic             stall;
  logic             we_a, we_b, fav, fbv, tv, tovf, tready;
  logic [4:0]       wa_a, wa_b, far, fbr;
  logic [31:0]      wd_a, wd_b, fad, fbd, tpc, tinst;
  logic [63:0]      cyc, ret;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cyc = 0;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk(clk), .reset(reset), .ex_a_in(ex_a), .ex_b_in(ex_b), .stall_in(stall),
    .rf_we_a(we_a), .rf_waddr_a(wa_a), .rf_wdata_a(wd_a),
    .rf_we_b(we_b), .rf_waddr_b(wa_b), .rf_wdata_b(wd_b),
    .fwd_a_valid(fav), .fwd_a_rd(far), .fwd_a_data(fad),
    .fwd_b_valid(fbv), .fwd_b_rd(fbr), .fwd_b_data(fbd),
    .cycle_cnt(cyc), .instret_cnt(ret),
    .trace_valid(tv), .trace_pc(tpc), .trace_inst(tinst),
    .trace_ready(tready), .trace_overflow(tovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_cyc++;
  endtask

  function automatic execute_signals_t mk(input logic v, input logic rw, input logic [4:0] rd,
                                          input logic [31:0] res, input logic [31:0] pc);
    execute_signals_t e;
    e.valid = v; e.reg_write = rw; e.rd = rd; e.result = res;
    e.pc = pc; e.inst = pc ^ 32'hA5A5_0000;
    return e;
  endfunction

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    tready = 1'b0;
    ex_a   = '0;
    ex_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_a", we_a, 0);
    chk("rst_we_b", we_b, 0);
    chk("rst_fav", fav, 0);
    chk("rst_fbv", fbv, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_ret", ret, 0);
    chk("rst_tv", tv, 0);
    chk("rst_tovf", tovf, 0);
    reset = 1'b0;
    exp_cyc = 0;

    // Single commit on lane A
    ex_a = mk(1, 1, 5'd5, 32'hDEAD_BEEF, 32'h100);
    ex_b = '0;
    step();
    chk("single_we_a", we_a, 1);
    chk("single_wa_a", wa_a, 5);
    chk("single_wd_a", wd_a, 32'hDEAD_BEEF);
    chk("single_we_b", we_b, 0);
    chk("single_fav", fav, 1);
    ex_a = '0;
    step();
    chk("single_ret", ret, 1);
    chk("single_we_a_off", we_a, 0);
    chk("single_cyc", cyc, 64'(exp_cyc));

    // WAW: same rd on both lanes, younger lane B wins
    ex_a = mk(1, 1, 5'd7, 32'h1, 32'h104);
    ex_b = mk(1, 1, 5'd7, 32'h2, 32'h108);
    step();
    chk("waw_we_a", we_a, 0);
    chk("waw_we_b", we_b, 1);
    chk("waw_wa_b", wa_b, 7);
    chk("waw_wd_b", wd_b, 2);
    chk("waw_fav", fav, 0);
    chk("waw_fbv", fbv, 1);
    ex_a = '0; ex_b = '0;
    step();
    chk("waw_ret", ret, 3);

    // Write to x0 and a store: no writes, both retire
    ex_a = mk(1, 1, 5'd0, 32'h55, 32'h10C);
    ex_b = mk(1, 0, 5'd9, 32'h66, 32'h110);
    step();
    chk("x0_we_a", we_a, 0);
    chk("st_we_b", we_b, 0);
    chk("x0_fav", fav, 0);
    chk("st_fbv", fbv, 0);
    ex_a = '0; ex_b = '0;
    step();
    chk("x0st_ret", ret, 5);

    // Stall holds the WB pair for three cycles, then it commits once
    ex_a = mk(1, 1, 5'd3, 32'h33, 32'h114);
    ex_b = mk(1, 1, 5'd4, 32'h44, 32'h118);
    step();
    stall = 1'b1;
    ex_a = mk(1, 1, 5'd9, 32'h99, 32'h200);
    ex_b = mk(1, 1, 5'd10, 32'hAA, 32'h204);
    #1;
    chk("stall_we_a", we_a, 0);
    chk("stall_we_b", we_b, 0);
    chk("stall_fav", fav, 1);
    repeat (3) step();
    chk("stall_ret", ret, 5);
    chk("stall_cyc", cyc, 64'(exp_cyc));
    chk("stall_hold_rd", far, 3);
    chk("stall_hold_d", fad, 32'h33);
    chk("stall_hold_rdb", fbr, 4);
    stall = 1'b0;
    ex_a = '0; ex_b = '0;
    #1;
    chk("rel_we_a", we_a, 1);
    chk("rel_wa_a", wa_a, 3);
    chk("rel_wd_a", wd_a, 32'h33);
    chk("rel_we_b", we_b, 1);
    chk("rel_wa_b", wa_b, 4);
    step();
    chk("rel_ret", ret, 7);
    chk("rel_we_a_off", we_a, 0);

    // Reset mid-operation with a held pair at cycle 100
    ex_a = mk(1, 1, 5'd11, 32'hB1, 32'h300);
    ex_b = mk(1, 1, 5'd12, 32'hB2, 32'h304);
    step();
    stall = 1'b1;
    ex_a = '0; ex_b = '0;
    while (exp_cyc < 100) step();
    chk("pre_rst_cyc", cyc, 100);
    stall = 1'b0;
    #1;
    chk("pre_rst_we_a", we_a, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we_a", we_a, 0);
    chk("mid_rst_we_b", we_b, 0);
    chk("mid_rst_fav", fav, 0);
    chk("mid_rst_fbv", fbv, 0);
    chk("mid_rst_cyc", cyc, 0);
    chk("mid_rst_ret", ret, 0);
    reset = 1'b0;
    exp_cyc = 0;
    step();
    chk("post_rst_cyc", cyc, 1);
    chk("post_rst_ret", ret, 0);

`ifdef WB_COMMIT_TRACE_EN
    // Five dual pairs into an 8-deep trace with no pops: last pair dropped
    for (int k = 0; k < 5; k++) begin
      ex_a = mk(1, 1, 5'd1, 32'h0, 32'h1000 + 32'(k) * 8);
      ex_b = mk(1, 1, 5'd2, 32'h0, 32'h1004 + 32'(k) * 8);
      step();
    end
    ex_a = '0; ex_b = '0;
    step();
    chk("trc_ret", ret, 10);
    chk("trc_ovf", tovf, 1);
    chk("trc_valid", tv, 1);
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("trc_drain_v", tv, 1);
      chk("trc_drain_pc", tpc, 32'h1000 + 32'(i) * 4);
      chk("trc_drain_inst", tinst, (32'h1000 + 32'(i) * 4) ^ 32'hA5A5_0000);
      step();
    end
    chk("trc_empty", tv, 0);
    chk("trc_ovf_sticky", tovf, 1);
`else
    // Trace disabled: outputs tied off regardless of commits and ready
    tready = 1'b1;
    ex_a = mk(1, 1, 5'd1, 32'h1, 32'h1000);
    ex_b = mk(1, 1, 5'd2, 32'h2, 32'h1004);
    step();
    ex_a = '0; ex_b = '0;
    step();
    chk("notrc_ret", ret, 2);
    chk("notrc_valid", tv, 0);
    chk("notrc_ovf", tovf, 0);
    chk("notrc_pc", tpc, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
Writeback/commit stage of the dual-issue pipeline. Sits directly downstream of the two execute datapaths (lane A = ALU/branch, lane B = memory + ALU) and consumes their registered execute_signals_t outputs. Holds one WB pipeline register per lane, resolves same-cycle write conflicts, and drives the register-file write ports and WB-stage forwarding values. Maintains 64-bit cycle and instret counters.

Parameters:
XLEN, 32, data width of results and PC
CNT_W, 64, width of cycle/instret counters
TRACE_DEPTH, 8, commit-trace FIFO entries (power of 2; used only with WB_COMMIT_TRACE_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ex_a_in  in  execute_signals_t  lane A execute result (older instruction of the pair)
ex_b_in  in  execute_signals_t  lane B execute result (younger instruction of the pair)
stall_in  in  1  hold WB registers and do not commit
rf_we_a  out  1  regfile write enable, port A
rf_waddr_a  out  5  regfile write address, port A
rf_wdata_a  out  XLEN  regfile write data, port A
rf_we_b  out  1  regfile write enable, port B
rf_waddr_b  out  5  regfile write address, port B
rf_wdata_b  out  XLEN  regfile write data, port B
fwd_a_valid / fwd_a_rd / fwd_a_data  out  1/5/XLEN  WB-stage forward source, lane A
fwd_b_valid / fwd_b_rd / fwd_b_data  out  1/5/XLEN  WB-stage forward source, lane B
cycle_cnt  out  CNT_W  cycles since reset
instret_cnt  out  CNT_W  instructions retired since reset
trace_valid  out  1  trace FIFO non-empty (WB_COMMIT_TRACE_EN only; else tied 0)
trace_pc / trace_inst  out  XLEN/32  head trace entry
trace_ready  in  1  pop trace head when trace_valid
trace_overflow  out  1  sticky: a commit was dropped because the FIFO was full

Behaviour:
- Reset: WB registers cleared (valid=0), all rf_we*/fwd_*_valid = 0, counters = 0, trace FIFO empty, trace_overflow = 0.
- Capture: each posedge with stall_in=0, wb_a <= ex_a_in and wb_b <= ex_b_in. With stall_in=1, WB registers hold and nothing commits.
- Commit occurs combinationally from WB registers when stall_in=0; latency ex -> regfile write is 1 cycle.
- Write enable: we_x = wb_x.valid & wb_x.reg_write & (wb_x.rd != 0) & ~stall_in.
- WAW: if both lanes are enabled and wb_a.rd == wb_b.rd, rf_we_a is forced to 0 (lane B is younger and wins). Lane A still counts as retired.
- fwd_x_valid = wb_x.valid & wb_x.reg_write & (rd != 0), independent of stall_in. Under WAW, fwd_a_valid = 0, so the hazard unit sees only the younger value.
- Retire: n = (wb_a.valid & ~stall_in) + (wb_b.valid & ~stall_in), which is 0..2. The count includes stores and branches. instret_cnt += n.
- cycle_cnt increments every cycle after reset. Both counters wrap modulo 2^CNT_W.
- Reset mid-stall: the asynchronous reset wins and all state clears immediately.

Optional Feature:
WB_COMMIT_TRACE_EN
- Defined: each committed lane pushes {pc, inst} into a TRACE_DEPTH FIFO. Lane A is pushed before lane B in the same cycle, so up to 2 pushes per cycle.
- The FIFO pops 1 entry per cycle when trace_valid & trace_ready. A pop and pushes may occur in the same cycle.
- Pushes that exceed the free space count (including the free slot created by a same-cycle pop) drop the younger entry and set trace_overflow, which stays set until reset.
- Undefined: no FIFO is instantiated; trace_valid, trace_overflow, trace_pc and trace_inst are tied to 0, and trace_ready is ignored.

Decomposition:
- Shared package: execute_signals_t (already defined), a new commit_trace_t {pc, inst}, and the constant REG_X0 = 5'd0.
- Sub-module: commit_trace_fifo (2-push/1-pop FIFO), instantiated only under WB_COMMIT_TRACE_EN.

Test Plan:
- Single commit: ex_a valid, reg_write, rd=5, result=32'hDEAD_BEEF; ex_b invalid -> next cycle rf_we_a=1, waddr_a=5, wdata_a=DEADBEEF, rf_we_b=0, instret +1.
- WAW: both lanes rd=7, A=32'h1, B=32'h2 -> rf_we_a=0, rf_we_b=1 with data 2, fwd_a_valid=0, instret +2.
- x0 and store: lane A rd=0 with reg_write=1; lane B store (reg_write=0) -> no write enables, instret +2.
- Stall: stall_in=1 for 3 cycles with a valid pair in WB -> no writes, instret unchanged, cycle_cnt +3, WB registers hold. Release -> pair commits once.
- Reset mid-operation: assert reset with a valid pair and cycle_cnt=100 -> all outputs 0 in the same cycle, counters restart from 0.
- Trace (WB_COMMIT_TRACE_EN, depth 8, trace_ready=0): commit 5 dual pairs -> 8 entries stored in order A0,B0,A1,B1…, trace_overflow=1. Then trace_ready=1 -> entries drain in that order.
